// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and flow controller for the 5-stage ARMv8 pipeline. It sits beside
// the decode stage and drives the write-enable and flush controls of the PC and
// of the IF/ID, ID/EX and EX/MEM pipeline registers.
//
//   * Load-use hazards: a load in EX whose destination is read by the
//     instruction in decode stalls the PC and IF/ID for one cycle. It also
//     injects a bubble into ID/EX. Register X31 (XZR) never creates a hazard.
//   * Taken branches: a branch that resolves taken in MEM squashes the
//     three wrong-path instructions in IF/ID, ID/EX and EX/MEM. The PC loads
//     the branch target in the same cycle.
//   * Branch sequencing (stall mode): a branch in decode holds fetch for two
//     cycles, until the branch reaches MEM and resolves.
//
// Priority: taken flush, then load-use stall, then branch sequencing.
//
// Optional feature macro: BRANCH_PREDICT_NT_EN
//   defined   -> fetch continues past branches (predict not-taken). Only a
//                taken flush squashes wrong-path work. The BR_WAIT states are
//                never entered.
//   undefined -> stall mode (default build).
//
// Parameters:
//   REG_W  register index width
//   CNT_W  width of each saturating performance counter
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   id_rn          decode-stage Rn
//   id_rm          decode-stage second read register (after the Reg2Loc mux)
//   id_uses_rm     decode instruction reads id_rm
//   id_is_branch   decode instruction is B, CBZ or B.LT
//   ex_memread     EX-stage instruction is a load
//   ex_rd          EX-stage destination register
//   mem_br_valid   MEM-stage instruction is a branch
//   mem_br_taken   MEM-stage branch is taken (qualified by mem_br_valid)
//   pc_write_en    PC may update
//   ifid_write_en  IF/ID may load
//   ifid_flush     IF/ID loads a NOP
//   idex_bubble    ID/EX loads zeroed control bits
//   exmem_flush    EX/MEM loads zeroed control bits
//   stall_cycles   saturating count of load-use stall cycles
//   flush_events   saturating count of taken-branch flushes
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rm,
    input  logic             id_is_branch,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_br_valid,
    input  logic             mem_br_taken,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_WAIT1 = 2'd1,
        BR_WAIT2 = 2'd2
    } state_t;

    // X31 reads as zero, so a load targeting it never feeds a real value.
    localparam logic [REG_W-1:0] XZR_IDX = REG_W'(31);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic             lu;
    logic             tf;
    logic             stall_inc;
    logic             flush_inc;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // -------------------------------------------------------------------------
    // Event detection
    // -------------------------------------------------------------------------
    assign lu = ex_memread && (ex_rd != XZR_IDX) &&
                ((id_rn == ex_rd) || (id_uses_rm && (id_rm == ex_rd)));

    // A stray mem_br_taken without mem_br_valid is ignored here.
    assign tf = mem_br_valid && mem_br_taken;

`ifdef BRANCH_PREDICT_NT_EN
    // Decode branches are not sequenced when fetch predicts not-taken.
    logic unused_id_is_branch;
    assign unused_id_is_branch = id_is_branch;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; combinational blocks below use blocking (=).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        exmem_flush   = 1'b0;
        state_next    = state;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;

        if (!reset) begin
            // Outputs are forced to their idle values while reset is held,
            // whatever the pipeline inputs are doing.
            state_next = RUN;
        end else if (tf) begin
            // The branch in MEM was taken. Kill the three younger instructions
            // and let the PC load the target. Any pending sequencing is moot.
            exmem_flush = 1'b1;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
            pc_write_en = 1'b1;
            state_next  = RUN;
            flush_inc   = 1'b1;
        end else if (lu && (state == RUN)) begin
            // Hold the consumer in decode for one cycle. Next cycle the load
            // is in MEM and PreWriteData forwarding covers the operand.
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
            state_next    = RUN;
            stall_inc     = 1'b1;
        end else begin
`ifdef BRANCH_PREDICT_NT_EN
            state_next = RUN;
`else
            unique case (state)
                RUN: begin
                    if (id_is_branch) begin
                        // The branch moves on to EX. Refetch is held and the
                        // slot behind it becomes a NOP.
                        pc_write_en = 1'b0;
                        ifid_flush  = 1'b1;
                        state_next  = BR_WAIT1;
                    end
                end
                BR_WAIT1: begin
                    pc_write_en = 1'b0;
                    ifid_flush  = 1'b1;
                    state_next  = BR_WAIT2;
                end
                BR_WAIT2: begin
                    // The branch is in MEM and resolved not-taken, so fetch
                    // resumes on the fall-through path. A taken branch is
                    // handled by the flush path above.
                    pc_write_en = 1'b1;
                    state_next  = RUN;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Saturating performance counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cnt;
    assign flush_events = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed bench for pipeline_hazard_ctrl. The five control outputs are packed
// as ctrl = {pc_write_en, ifid_write_en, ifid_flush, idex_bubble, exmem_flush}
// and compared against hand-computed codes.
// Inputs change 1 time unit after a rising edge. Outputs are sampled 1 time
// unit after that, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    // ctrl codes {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush}
    localparam logic [4:0] C_RUN   = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00010;
    localparam logic [4:0] C_FLUSH = 5'b11111;
`ifdef BRANCH_PREDICT_NT_EN
    localparam logic [4:0] C_BRSEQ = 5'b11000;  // fetch runs past the branch
`else
    localparam logic [4:0] C_BRSEQ = 5'b01100;  // PC held, IF/ID gets a NOP
`endif

    logic             clk;
    logic             reset;
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic             id_uses_rm;
    logic             id_is_branch;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rd;
    logic             mem_br_valid;
    logic             mem_br_taken;
    logic             pc_write_en;
    logic             ifid_write_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    logic [4:0]       ctrl;

    int n_vec = 0;
    int n_err = 0;

    pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rn         (id_rn),
        .id_rm         (id_rm),
        .id_uses_rm    (id_uses_rm),
        .id_is_branch  (id_is_branch),
        .ex_memread    (ex_memread),
        .ex_rd         (ex_rd),
        .mem_br_valid  (mem_br_valid),
        .mem_br_taken  (mem_br_taken),
        .pc_write_en   (pc_write_en),
        .ifid_write_en (ifid_write_en),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .exmem_flush   (exmem_flush),
        .stall_cycles  (stall_cycles),
        .flush_events  (flush_events)
    );

    assign ctrl = {pc_write_en, ifid_write_en, ifid_flush, idex_bubble, exmem_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rn        = '0;
        id_rm        = '0;
        id_uses_rm   = 1'b0;
        id_is_branch = 1'b0;
        ex_memread   = 1'b0;
        ex_rd        = '0;
        mem_br_valid = 1'b0;
        mem_br_taken = 1'b0;
    endtask

    task automatic drive_lu(input logic [REG_W-1:0] rd);
        ex_memread = 1'b1;
        ex_rd      = rd;
        id_rn      = rd;
    endtask

    // Reset held with hazard and flush inputs active: outputs must stay idle.
    task automatic test_reset();
        reset = 1'b0;
        drive_lu(5'd1);
        mem_br_valid = 1'b1;
        mem_br_taken = 1'b1;
        id_is_branch = 1'b1;
        #1;
        n_vec++;
        if (ctrl !== C_RUN) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want %b", ctrl, C_RUN);
        end
        step();
        step();
        n_vec++;
        if (stall_cycles !== 16'd0 || flush_events !== 16'd0) begin
            n_err++;
            $display("FAIL reset_counters: got stall=%0d flush=%0d want 0 0", stall_cycles, flush_events);
        end
        clear_inputs();
        reset = 1'b1;
        #1;
        n_vec++;
        if (ctrl !== C_RUN) begin
            n_err++;
            $display("FAIL reset_release_ctrl: got %b want %b", ctrl, C_RUN);
        end
        step();
    endtask

    task automatic test_load_use();
        // LDUR X1 in EX, ADD reading X1 in decode
        drive_lu(5'd1);
        #1;
        n_vec++;
        if (ctrl !== C_STALL) begin
            n_err++;
            $display("FAIL lu_rn_ctrl: got %b want %b", ctrl, C_STALL);
        end
        step();
        clear_inputs();
        #1;
        n_vec++;
        if (stall_cycles !== 16'd1 || ctrl !== C_RUN) begin
            n_err++;
            $display("FAIL lu_rn_after: got stall=%0d ctrl=%b want 1 %b", stall_cycles, ctrl, C_RUN);
        end
        // Hazard through the second read port
        ex_memread = 1'b1;
        ex_rd      = 5'd7;
        id_rn      = 5'd2;
        id_rm      = 5'd7;
        id_uses_rm = 1'b1;
        #1;
        n_vec++;
        if (ctrl !== C_STALL) begin
            n_err++;
            $display("FAIL lu_rm_ctrl: got %b want %b", ctrl, C_STALL);
        end
        step();
        // Same registers but the decode instruction does not read Rm
        id_uses_rm = 1'b0;
        #1;
        n_vec++;
        if (ctrl !== C_RUN || stall_cycles !== 16'd2) begin
            n_err++;
            $display("FAIL lu_rm_unused: got ctrl=%b stall=%0d want %b 2", ctrl, stall_cycles, C_RUN);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_no_hazard();
        // Load into XZR never stalls
        ex_memread = 1'b1;
        ex_rd      = 5'd31;
        id_rn      = 5'd31;
        id_rm      = 5'd31;
        id_uses_rm = 1'b1;
        #1;
        n_vec++;
        if (ctrl !== C_RUN) begin
            n_err++;
            $display("FAIL lu_xzr: got %b want %b", ctrl, C_RUN);
        end
        step();
        // Non-load producer with a matching register
        ex_memread = 1'b0;
        ex_rd      = 5'd4;
        id_rn      = 5'd4;
        #1;
        n_vec++;
        if (ctrl !== C_RUN) begin
            n_err++;
            $display("FAIL no_load: got %b want %b", ctrl, C_RUN);
        end
        step();
        clear_inputs();
        #1;
        n_vec++;
        if (stall_cycles !== 16'd2) begin
            n_err++;
            $display("FAIL no_hazard_count: got %0d want 2", stall_cycles);
        end
    endtask

    task automatic test_taken_flush();
        // Taken branch coincident with a load-use: flush wins
        drive_lu(5'd3);
        mem_br_valid = 1'b1;
        mem_br_taken = 1'b1;
        #1;
        n_vec++;
        if (ctrl !== C_FLUSH) begin
            n_err++;
            $display("FAIL tf_over_lu: got %b want %b", ctrl, C_FLUSH);
        end
        step();
        clear_inputs();
        #1;
        n_vec++;
        if (flush_events !== 16'd1 || stall_cycles !== 16'd2) begin
            n_err++;
            $display("FAIL tf_counts: got flush=%0d stall=%0d want 1 2", flush_events, stall_cycles);
        end
        // mem_br_taken without mem_br_valid is ignored
        mem_br_taken = 1'b1;
        #1;
        n_vec++;
        if (ctrl !== C_RUN) begin
            n_err++;
            $display("FAIL taken_no_valid: got %b want %b", ctrl, C_RUN);
        end
        step();
        clear_inputs();
        #1;
        n_vec++;
        if (flush_events !== 16'd1) begin
            n_err++;
            $display("FAIL taken_no_valid_count: got %0d want 1", flush_events);
        end
    endtask

    task automatic test_branch_seq();
        // Not-taken branch: RUN -> BR_WAIT1 -> BR_WAIT2 -> RUN
        id_is_branch = 1'b1;
        #1;
        n_vec++;
        if (ctrl !== C_BRSEQ) begin
            n_err++;
            $display("FAIL br_run: got %b want %b", ctrl, C_BRSEQ);
        end
        step();
        id_is_branch = 1'b0;
        #1;
        n_vec++;
        if (ctrl !== C_BRSEQ) begin
            n_err++;
            $display("FAIL br_wait1: got %b want %b", ctrl, C_BRSEQ);
        end
        step();
        mem_br_valid = 1'b1;
        mem_br_taken = 1'b0;
        #1;
        n_vec++;
        if (ctrl !== C_RUN) begin
            n_err++;
            $display("FAIL br_wait2_nt: got %b want %b", ctrl, C_RUN);
        end
        step();
        clear_inputs();
        // Back in RUN: a load-use must stall again
        drive_lu(5'd9);
        #1;
        n_vec++;
        if (ctrl !== C_STALL) begin
            n_err++;
            $display("FAIL br_back_to_run: got %b want %b", ctrl, C_STALL);
        end
        step();
        clear_inputs();
        // Taken branch resolves in BR_WAIT2 and flushes
        id_is_branch = 1'b1;
        step();
        id_is_branch = 1'b0;
        step();
        mem_br_valid = 1'b1;
        mem_br_taken = 1'b1;
        #1;
        n_vec++;
        if (ctrl !== C_FLUSH) begin
            n_err++;
            $display("FAIL br_wait2_taken: got %b want %b", ctrl, C_FLUSH);
        end
        step();
        clear_inputs();
        #1;
        n_vec++;
        if (flush_events !== 16'd2 || stall_cycles !== 16'd3 || ctrl !== C_RUN) begin
            n_err++;
            $display("FAIL br_counts: got flush=%0d stall=%0d ctrl=%b want 2 3 %b", flush_events, stall_cycles, ctrl, C_RUN);
        end
    endtask

    task automatic test_lu_then_branch();
        // Load-use and branch together: stall first, then sequence the branch
        drive_lu(5'd5);
        id_is_branch = 1'b1;
        #1;
        n_vec++;
        if (ctrl !== C_STALL) begin
            n_err++;
            $display("FAIL lu_br_first: got %b want %b", ctrl, C_STALL);
        end
        step();
        ex_memread = 1'b0;
        #1;
        n_vec++;
        if (ctrl !== C_BRSEQ || stall_cycles !== 16'd4) begin
            n_err++;
            $display("FAIL lu_br_second: got ctrl=%b stall=%0d want %b 4", ctrl, stall_cycles, C_BRSEQ);
        end
        step();
        clear_inputs();
        #1;
        n_vec++;
        if (ctrl !== C_BRSEQ) begin
            n_err++;
            $display("FAIL lu_br_wait1: got %b want %b", ctrl, C_BRSEQ);
        end
        step();
        #1;
        n_vec++;
        if (ctrl !== C_RUN) begin
            n_err++;
            $display("FAIL lu_br_wait2: got %b want %b", ctrl, C_RUN);
        end
        step();
    endtask

    task automatic test_reset_mid_branch();
        id_is_branch = 1'b1;
        step();
        id_is_branch = 1'b0;
        #1;
        n_vec++;
        if (ctrl !== C_BRSEQ) begin
            n_err++;
            $display("FAIL mid_pre_reset: got %b want %b", ctrl, C_BRSEQ);
        end
        // Assert reset between edges while in BR_WAIT1
        reset = 1'b0;
        drive_lu(5'd2);
        #1;
        n_vec++;
        if (ctrl !== C_RUN || stall_cycles !== 16'd0 || flush_events !== 16'd0) begin
            n_err++;
            $display("FAIL mid_reset: got ctrl=%b stall=%0d flush=%0d want %b 0 0", ctrl, stall_cycles, flush_events, C_RUN);
        end
        step();
        reset = 1'b1;
        clear_inputs();
        #1;
        n_vec++;
        if (ctrl !== C_RUN) begin
            n_err++;
            $display("FAIL mid_reset_release: got %b want %b", ctrl, C_RUN);
        end
        step();
    endtask

    task automatic test_saturation();
        // 2^16 + 5 stall cycles: an unsaturated counter would wrap to 5
        drive_lu(5'd6);
        repeat (65541) @(posedge clk);
        #1;
        n_vec++;
        if (stall_cycles !== 16'hFFFF) begin
            n_err++;
            $display("FAIL stall_saturate: got %h want ffff", stall_cycles);
        end
        n_vec++;
        if (flush_events !== 16'd0) begin
            n_err++;
            $display("FAIL sat_flush_idle: got %0d want 0", flush_events);
        end
        clear_inputs();
        step();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        step();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_taken_flush();
        test_branch_seq();
        test_lu_then_branch();
        test_reset_mid_branch();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
